mod_alu: RTL and testbench

Parametrised modular arithmetic unit. It computes (a+b) mod m, (a−b) mod m or (a·b) mod m for a modulus m supplied at run time, with operand/result handshakes on both sides. It succeeds the fixed-modulus ModMul: it adds a runtime modulus, add/sub modes, input range checking and output backpressure. It sits between the point-arithmetic controller and operand storage in the MSM datapath.

---
 rtl/mod_alu_pkg.sv | 17 +
 rtl/mod_alu_if.sv | 26 ++
 rtl/mod_dbl_add_step.sv | 22 ++
 rtl/mod_alu.sv | 130 +++++++++++++
 tb/tb_mod_alu.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_alu_pkg.sv
// Shared encodings for the runtime-modulus arithmetic unit: operation codes and FSM states.
package mod_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mod_alu_if.sv
// Request/response bundle between the point-arithmetic controller (master) and mod_alu (slave).
interface mod_alu_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             err;
    logic             done;

    modport master (
        output in_valid, op, m, a, b, out_ready,
        input  in_ready, out_valid, r, err, done
    );

    modport slave (
        input  in_valid, op, m, a, b, out_ready,
        output in_ready, out_valid, r, err, done
    );
endinterface

// File: rtl/mod_dbl_add_step.sv
// One MSB-first multiply iteration: acc' = (2*acc + bit*a) mod m, assuming acc < m and a < m.
module mod_dbl_add_step #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_m,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_acc
);
    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_dbl;
    logic [WIDTH:0] w_dbl_red;
    logic [WIDTH:0] w_add;

    // Both partial results stay below 2m, so a single conditional subtract restores the range.
    assign w_m_ext   = {1'b0, i_m};
    assign w_dbl     = {i_acc, 1'b0};
    assign w_dbl_red = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
    assign w_add     = w_dbl_red + (i_bit ? {1'b0, i_a} : {(WIDTH+1){1'b0}});
    assign o_acc     = (w_add >= w_m_ext) ? WIDTH'(w_add - w_m_ext) : w_add[WIDTH-1:0];
endmodule

// File: rtl/mod_alu.sv
// Modular add/sub/mul unit with runtime modulus; one request in flight, result held until consumed.
module mod_alu
    import mod_alu_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic     clk,
    input  logic     reset,
    mod_alu_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic             r_err;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_valid_req;
    logic             w_is_mul;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_add_res;
    logic [WIDTH-1:0] w_sub_res;
    logic [WIDTH-1:0] w_addsub;
    logic [WIDTH-1:0] w_step;

    assign bus.in_ready  = (r_state == IDLE) && !reset;
    assign bus.out_valid = (r_state == RESP);
    assign bus.r         = r_res;
    assign bus.err       = r_err;
    assign bus.done      = r_done;

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_valid_req = (bus.m >= WIDTH'(2)) && (bus.a < bus.m) && (bus.b < bus.m)
                         && (bus.op != OP_RSVD);
    assign w_is_mul    = (bus.op == OP_MUL);

    // ADD/SUB complete in the accept cycle, straight from the live inputs.
    assign w_m_ext   = {1'b0, bus.m};
    assign w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_add_res = (w_sum >= w_m_ext) ? WIDTH'(w_sum - w_m_ext) : w_sum[WIDTH-1:0];
    assign w_sub_res = (bus.a >= bus.b) ? WIDTH'({1'b0, bus.a} - {1'b0, bus.b})
                                        : WIDTH'({1'b0, bus.a} - {1'b0, bus.b} + w_m_ext);
    assign w_addsub  = (bus.op == OP_SUB) ? w_sub_res : w_add_res;

    mod_dbl_add_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_a   (r_a),
        .i_m   (r_m),
        .i_bit (r_b[r_cnt]),
        .o_acc (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_valid_req && w_is_mul) ? MUL : RESP;
                end
            end
            MUL: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_res  <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_m   <= bus.m;
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_acc <= '0;
                r_cnt <= CW'(WIDTH - 1);
                if (!w_valid_req) begin
                    r_res  <= '0;
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                end else if (!w_is_mul) begin
                    r_res  <= w_addsub;
                    r_err  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_err  <= 1'b0;
                end
            end else if (r_state == MUL) begin
                r_acc <= w_step;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    r_res  <= w_step;
                    r_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mod_alu.sv
// Directed self-checking bench for mod_alu at WIDTH=128 and WIDTH=8.
module tb_mod_alu;
    import mod_alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mod_alu_if #(.WIDTH(128)) if128 ();
    mod_alu_if #(.WIDTH(8))   if8 ();

    mod_alu #(.WIDTH(128)) u_dut128 (.clk(clk), .reset(reset), .bus(if128));
    mod_alu #(.WIDTH(8))   u_dut8   (.clk(clk), .reset(reset), .bus(if8));

    task automatic issue128(input logic [1:0] op, input logic [127:0] m, input logic [127:0] a,
                            input logic [127:0] b);
        @(negedge clk);
        if128.op = op; if128.m = m; if128.a = a; if128.b = b;
        if128.in_valid = 1'b1;
        @(negedge clk);
        if128.in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] m, input logic [7:0] a,
                          input logic [7:0] b);
        @(negedge clk);
        if8.op = op; if8.m = m; if8.a = a; if8.b = b;
        if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; capped so a dead DUT cannot hang the run.
    task automatic wait128(output int n);
        n = 0;
        while (if128.out_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (if8.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (if128.in_ready !== 1'b0 || if128.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready=%0b out_valid=%0b required 0 0", if128.in_ready, if128.out_valid);
        end
        checks++;
        if (if128.r !== 128'd0 || if128.err !== 1'b0 || if128.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_out r=%0d err=%0b done=%0b required 0 0 0", if128.r, if128.err, if128.done);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (if128.in_ready !== 1'b1 || if8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%0b/%0b required 1/1", if128.in_ready, if8.in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_mul_basic();
        int n;
        if128.out_ready = 1'b1;
        issue128(OP_MUL, 128'd37, 128'd12, 128'd34);
        // Inputs changing after the accept must not disturb the captured operands.
        if128.m = 128'd5; if128.a = '1; if128.b = '1;
        checks++;
        if (if128.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy in_ready=%0b required 0", if128.in_ready);
        end
        wait128(n);
        checks++;
        if (n !== 128) begin
            errors++;
            $display("FAIL mul_latency edges=%0d required 128", n);
        end
        checks++;
        if (if128.r !== 128'd1 || if128.err !== 1'b0 || if128.done !== 1'b1) begin
            errors++;
            $display("FAIL mul_12x34 r=%0d err=%0b done=%0b required 1 0 1", if128.r, if128.err, if128.done);
        end
        @(negedge clk);
        checks++;
        if (if128.out_valid !== 1'b0 || if128.done !== 1'b0 || if128.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_consume out_valid=%0b done=%0b in_ready=%0b required 0 0 1",
                     if128.out_valid, if128.done, if128.in_ready);
        end
        issue128(OP_MUL, 128'd37, 128'd36, 128'd36);
        wait128(n);
        checks++;
        if (if128.r !== 128'd1 || n !== 128) begin
            errors++;
            $display("FAIL mul_36x36 r=%0d edges=%0d required 1 128", if128.r, n);
        end
        $display("test_mul_basic done");
    endtask

    task automatic test_addsub();
        logic [1:0]   ops [3] = '{OP_ADD, OP_SUB, OP_SUB};
        logic [127:0] av  [3] = '{128'd30, 128'd5, 128'd9};
        logic [127:0] bv  [3] = '{128'd20, 128'd9, 128'd5};
        logic [127:0] ev  [3] = '{128'd13, 128'd33, 128'd4};
        if128.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue128(ops[i], 128'd37, av[i], bv[i]);
            checks++;
            if (if128.out_valid !== 1'b1 || if128.done !== 1'b1 || if128.r !== ev[i] || if128.err !== 1'b0) begin
                errors++;
                $display("FAIL addsub_%0d out_valid=%0b done=%0b r=%0d err=%0b required 1 1 %0d 0",
                         i, if128.out_valid, if128.done, if128.r, if128.err, ev[i]);
            end
            @(negedge clk);
        end
        $display("test_addsub done");
    endtask

    task automatic test_errors();
        logic [1:0]   ops [3] = '{OP_ADD, OP_RSVD, OP_MUL};
        logic [127:0] mv  [3] = '{128'd37, 128'd37, 128'd1};
        logic [127:0] av  [3] = '{128'd37, 128'd3, 128'd0};
        if128.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue128(ops[i], mv[i], av[i], 128'd1 - (mv[i] == 128'd1 ? 128'd1 : 128'd0));
            checks++;
            if (if128.out_valid !== 1'b1 || if128.err !== 1'b1 || if128.r !== 128'd0 || if128.done !== 1'b1) begin
                errors++;
                $display("FAIL err_%0d out_valid=%0b err=%0b r=%0d done=%0b required 1 1 0 1",
                         i, if128.out_valid, if128.err, if128.r, if128.done);
            end
            @(negedge clk);
        end
        $display("test_errors done");
    endtask

    task automatic test_width8();
        int n;
        logic [7:0] mv [3] = '{8'd255, 8'd255, 8'd13};
        logic [7:0] av [3] = '{8'd254, 8'd0, 8'd7};
        logic [7:0] bv [3] = '{8'd254, 8'd200, 8'd9};
        logic [7:0] ev [3] = '{8'd1, 8'd0, 8'd11};
        if8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue8(OP_MUL, mv[i], av[i], bv[i]);
            wait8(n);
            checks++;
            if (n !== 8 || if8.r !== ev[i] || if8.err !== 1'b0 || if8.done !== 1'b1) begin
                errors++;
                $display("FAIL w8_mul_%0d edges=%0d r=%0d err=%0b done=%0b required 8 %0d 0 1",
                         i, n, if8.r, if8.err, if8.done, ev[i]);
            end
            @(negedge clk);
        end
        $display("test_width8 done");
    endtask

    task automatic test_backpressure();
        int n;
        if128.out_ready = 1'b0;
        issue128(OP_MUL, 128'd37, 128'd12, 128'd34);
        wait128(n);
        checks++;
        if (n !== 128 || if128.done !== 1'b1 || if128.r !== 128'd1) begin
            errors++;
            $display("FAIL bp_first edges=%0d done=%0b r=%0d required 128 1 1", n, if128.done, if128.r);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if128.out_valid !== 1'b1 || if128.done !== 1'b0 || if128.in_ready !== 1'b0
                || if128.r !== 128'd1 || if128.err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d out_valid=%0b done=%0b in_ready=%0b r=%0d err=%0b required 1 0 0 1 0",
                         i, if128.out_valid, if128.done, if128.in_ready, if128.r, if128.err);
            end
        end
        if128.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (if128.out_valid !== 1'b0 || if128.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release out_valid=%0b in_ready=%0b required 0 1", if128.out_valid, if128.in_ready);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        if128.out_ready = 1'b1;
        issue128(OP_MUL, 128'd37, 128'd12, 128'd34);
        repeat (59) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (if128.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_inready in_ready=%0b required 0", if128.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (if128.in_ready !== 1'b1 || if128.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle in_ready=%0b out_valid=%0b required 1 0", if128.in_ready, if128.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (if128.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_discard out_valid_cycles=%0d required 0", seen);
        end
        issue128(OP_MUL, 128'd37, 128'd12, 128'd34);
        wait128(n);
        checks++;
        if (n !== 128 || if128.r !== 128'd1 || if128.err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fresh edges=%0d r=%0d err=%0b required 128 1 0", n, if128.r, if128.err);
        end
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

    initial begin
        if128.in_valid = 1'b0; if128.out_ready = 1'b1;
        if128.op = 2'b00; if128.m = '0; if128.a = '0; if128.b = '0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b1;
        if8.op = 2'b00; if8.m = '0; if8.a = '0; if8.b = '0;
        test_reset();
        test_mul_basic();
        test_addsub();
        test_errors();
        test_width8();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
